// File: rtl/blk_8b790e_if.sv
// Avalon-MM debug slave bus between the CPU and the OCI memory controller.
interface blk_8b790e_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    input  cpu_readdata, cpu_waitrequest
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable,
    output cpu_readdata, cpu_waitrequest
  );
endinterface

// File: rtl/blk_8b790e.sv
// Sysclk-side OCI debug memory controller: sequences JTAG reads/writes into the
// single-port debug RAM and shares that RAM round-robin with the CPU debug slave.
module blk_8b790e #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  blk_8b790e_if.slave       cpu,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  typedef enum logic [1:0] {IDLE, JTAG_RD, CPU_RD} state_e;
  typedef enum logic {GNT_CPU, GNT_JTAG} grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic              pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic [31:0]       mon_dreg_q, mon_dreg_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  logic cpu_req, jtag_busy, any_action, grant_jtag, grant_cpu;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign cpu_req    = cpu.cpu_read | cpu.cpu_write;
  assign jtag_busy  = pend_q | (state_q == JTAG_RD);
  assign any_action = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  // On a tie the requester that did not win last time gets the RAM.
  assign grant_jtag = (state_q == IDLE) && pend_q && (!cpu_req || last_grant_q == GNT_CPU);
  assign grant_cpu  = (state_q == IDLE) && cpu_req && !grant_jtag;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_d             = state_q;
    last_grant_d        = last_grant_q;
    jtag_addr_d         = jtag_addr_q;
    pend_d              = pend_q;
    pend_wr_d           = pend_wr_q;
    pend_data_d         = pend_data_q;
    mon_dreg_d          = mon_dreg_q;
    ready_d             = ready_q;
    error_d             = error_q;
    ram_address         = '0;
    ram_wren            = 1'b0;
    ram_byteen          = 4'h0;
    ram_wdata           = '0;
    cpu.cpu_readdata    = '0;
    cpu.cpu_waitrequest = cpu_req;

    // A busy controller drops the new action entirely and flags it.
    if (any_action && jtag_busy) begin
      error_d = 1'b1;
    end else if (take_action_ocimem_a) begin
      jtag_addr_d = jdo[17 +: ADDR_W];
      error_d     = 1'b0;
      if (jdo[34]) begin
        pend_d    = 1'b1;
        pend_wr_d = 1'b0;
        ready_d   = 1'b0;
      end
    end else if (take_action_ocimem_b) begin
      pend_d      = 1'b1;
      pend_wr_d   = 1'b1;
      pend_data_d = jdo[34:3];
      ready_d     = 1'b0;
    end else if (take_no_action_ocimem_a) begin
      pend_d    = 1'b1;
      pend_wr_d = 1'b0;
      ready_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (grant_jtag) begin
          last_grant_d = GNT_JTAG;
          ram_address  = jtag_addr_q;
          pend_d       = 1'b0;
          if (pend_wr_q) begin
            ram_wren    = 1'b1;
            ram_byteen  = 4'hF;
            ram_wdata   = pend_data_q;
            ready_d     = 1'b1;
            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
          end else begin
            state_d = JTAG_RD;
          end
        end else if (grant_cpu) begin
          last_grant_d = GNT_CPU;
          ram_address  = cpu.cpu_address;
          if (cpu.cpu_write) begin
            ram_wren            = 1'b1;
            ram_byteen          = cpu.cpu_byteenable;
            ram_wdata           = cpu.cpu_writedata;
            cpu.cpu_waitrequest = 1'b0;
          end else begin
            state_d = CPU_RD;
          end
        end
      end
      JTAG_RD: begin
        mon_dreg_d  = ram_rdata;
        ready_d     = 1'b1;
        jtag_addr_d = jtag_addr_q + ADDR_W'(1);
        state_d     = IDLE;
      end
      CPU_RD: begin
        cpu.cpu_readdata    = ram_rdata;
        cpu.cpu_waitrequest = 1'b0;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_CPU;
      jtag_addr_q  <= '0;
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_data_q  <= '0;
      mon_dreg_q   <= '0;
      ready_q      <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      jtag_addr_q  <= jtag_addr_d;
      pend_q       <= pend_d;
      pend_wr_q    <= pend_wr_d;
      pend_data_q  <= pend_data_d;
      mon_dreg_q   <= mon_dreg_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
endmodule

// File: tb/tb_blk_8b790e.sv
// Scoreboard bench for blk_8b790e: directed JTAG/CPU traffic against a registered RAM model.
module tb_blk_8b790e;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        act_a, act_b, noact_a;
  logic [7:0]  ram_address;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mon_dreg;
  logic        monitor_ready, monitor_error;

  blk_8b790e_if #(.ADDR_W(8)) bus ();

  blk_8b790e #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (act_a),
    .take_action_ocimem_b    (act_b),
    .take_no_action_ocimem_a (noact_a),
    .cpu                     (bus),
    .ram_address             (ram_address),
    .ram_wren                (ram_wren),
    .ram_byteen              (ram_byteen),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wren_cnt = 0;
  int jtag_done_cyc = 0;
  int cpu_done_cyc = 0;
  logic prev_ready = 1'b1;
  logic [31:0] mem [0:255];
  logic [31:0] exp_mon_q [$];
  logic [31:0] exp_cpu_q [$];
  logic [31:0] exp_mondreg = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Registered single-port RAM model with byte enables.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_address][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_address];
    if (reset_n && ram_wren) wren_cnt <= wren_cnt + 1;
  end

  // Monitor: JTAG completion on monitor_ready rising, CPU read on waitrequest low.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_mon_q.delete();
      exp_cpu_q.delete();
      prev_ready <= 1'b1;
    end else begin
      if (monitor_ready && !prev_ready) begin
        jtag_done_cyc <= cyc - 1;
        if (exp_mon_q.size() == 0) check("spurious_jtag_done", 32'(exp_mon_q.size()), 32'd1);
        else check("mondreg", mon_dreg, exp_mon_q.pop_front());
      end
      if (bus.cpu_read && !bus.cpu_write && !bus.cpu_waitrequest) begin
        cpu_done_cyc <= cyc;
        if (exp_cpu_q.size() == 0) check("spurious_cpu_read", 32'(exp_cpu_q.size()), 32'd1);
        else check("cpu_readdata", bus.cpu_readdata, exp_cpu_q.pop_front());
      end
      prev_ready <= monitor_ready;
    end
  end

  function automatic logic [37:0] mk_a(input logic rd, input logic [7:0] addr);
    logic [37:0] j = '0;
    j[34]    = rd;
    j[24:17] = addr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] data);
    logic [37:0] j = '0;
    j[34:3] = data;
    return j;
  endfunction

  // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a
  task automatic pulse(input int kind, input logic [37:0] j);
    @(posedge clk); #1;
    jdo = j;
    act_a = (kind == 0);
    act_b = (kind == 1);
    noact_a = (kind == 2);
    @(posedge clk); #1;
    act_a = 1'b0;
    act_b = 1'b0;
    noact_a = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (exp_mon_q.size() == 0 && monitor_ready) ok = 1'b1;
    end
    check("jtag_drain", 32'(ok), 32'd1);
  endtask

  task automatic cpu_rd(input logic [7:0] a, input logic [31:0] exp, output int waits);
    bit done = 1'b0;
    waits = 0;
    exp_cpu_q.push_back(exp);
    @(posedge clk); #1;
    bus.cpu_address = a;
    bus.cpu_read = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!bus.cpu_waitrequest) done = 1'b1;
      else waits++;
    end
    check("cpu_rd_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    bus.cpu_read = 1'b0;
  endtask

  task automatic cpu_rd_burst(input logic [7:0] a, input logic [31:0] exp, input int n);
    int got = 0;
    for (int i = 0; i < n; i++) exp_cpu_q.push_back(exp);
    @(posedge clk); #1;
    bus.cpu_address = a;
    bus.cpu_read = 1'b1;
    for (int i = 0; i < 60 && got < n; i++) begin
      @(negedge clk);
      if (!bus.cpu_waitrequest) got++;
    end
    check("cpu_burst_done", 32'(got), 32'(n));
    @(posedge clk); #1;
    bus.cpu_read = 1'b0;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, output int waits);
    bit done = 1'b0;
    waits = 0;
    @(posedge clk); #1;
    bus.cpu_address = a;
    bus.cpu_writedata = d;
    bus.cpu_byteenable = 4'hF;
    bus.cpu_write = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!bus.cpu_waitrequest) done = 1'b1;
      else waits++;
    end
    check("cpu_wr_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    bus.cpu_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    int waits;
    int wren_before;
    bit ready_held;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset_n = 1'b0;
    jdo = '0;
    act_a = 1'b0;
    act_b = 1'b0;
    noact_a = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_writedata = '0;
    bus.cpu_byteenable = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_mondreg", mon_dreg, 32'h0);
    check("rst_ready", 32'(monitor_ready), 32'd1);
    check("rst_error", 32'(monitor_error), 32'd0);
    check("rst_waitreq", 32'(bus.cpu_waitrequest), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_cpu_rdata", bus.cpu_readdata, 32'h0);

    // Address load without read: no op queued, no RAM write
    wren_before = wren_cnt;
    pulse(0, mk_a(1'b0, 8'h10));
    ready_held = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!monitor_ready) ready_held = 1'b0;
    end
    check("a_noread_ready", 32'(ready_held), 32'd1);
    check("a_noread_wren", 32'(wren_cnt), 32'(wren_before));

    // Write DEADBEEF at 0x10, then read it back
    exp_mon_q.push_back(exp_mondreg);
    pulse(1, mk_b(32'hDEADBEEF));
    wait_idle();
    check("wr_mem10", mem[8'h10], 32'hDEADBEEF);
    pulse(0, mk_a(1'b0, 8'h10));
    exp_mondreg = 32'hDEADBEEF;
    exp_mon_q.push_back(exp_mondreg);
    pulse(2, '0);
    check("rd_ready_low", 32'(monitor_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rd_mondreg_early", mon_dreg, 32'h0);
    @(negedge clk);
    check("rd_mondreg", mon_dreg, 32'hDEADBEEF);
    wait_idle();
    // Post-increment must have moved jtag_addr to 0x11
    exp_mon_q.push_back(exp_mondreg);
    pulse(1, mk_b(32'h11111111));
    wait_idle();
    check("inc_mem11", mem[8'h11], 32'h11111111);
    check("inc_mem10_kept", mem[8'h10], 32'hDEADBEEF);

    // Address wrap at 0xFF
    pulse(0, mk_a(1'b0, 8'hFF));
    exp_mon_q.push_back(exp_mondreg);
    pulse(1, mk_b(32'hCAFEF00D));
    wait_idle();
    exp_mon_q.push_back(exp_mondreg);
    pulse(1, mk_b(32'h12345678));
    wait_idle();
    check("wrap_memff", mem[8'hFF], 32'hCAFEF00D);
    check("wrap_mem00", mem[8'h00], 32'h12345678);

    // CPU write leaves last_grant=CPU; then simultaneous JTAG read and CPU read
    cpu_wr(8'h20, 32'hA5A5A5A5, waits);
    check("cpu_wr_waits", 32'(waits), 32'd0);
    check("cpu_wr_mem20", mem[8'h20], 32'hA5A5A5A5);
    pulse(0, mk_a(1'b0, 8'h10));
    exp_mon_q.push_back(exp_mondreg);
    fork
      pulse(2, '0);
      begin
        @(posedge clk);
        cpu_rd(8'h20, 32'hA5A5A5A5, waits);
      end
    join
    wait_idle();
    check("rr_cpu_waits", 32'(waits), 32'd3);
    check("rr_latency", 32'(cpu_done_cyc - jtag_done_cyc), 32'd2);

    // Second write while the first is pending, CPU streaming reads
    pulse(0, mk_a(1'b0, 8'h30));
    fork
      cpu_rd_burst(8'h20, 32'hA5A5A5A5, 4);
      begin
        exp_mon_q.push_back(exp_mondreg);
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        jdo = mk_b(32'h11112222);
        act_b = 1'b1;
        @(posedge clk); #1;
        jdo = mk_b(32'h33334444);
        @(posedge clk); #1;
        act_b = 1'b0;
      end
    join
    wait_idle();
    check("busy_mem30", mem[8'h30], 32'h11112222);
    check("busy_mem31", mem[8'h31], 32'h0);
    check("busy_error", 32'(monitor_error), 32'd1);
    exp_mondreg = 32'hA5A5A5A5;
    exp_mon_q.push_back(exp_mondreg);
    pulse(0, mk_a(1'b1, 8'h20));
    check("error_cleared", 32'(monitor_error), 32'd0);
    wait_idle();

    // Asynchronous reset while the JTAG read is in flight
    pulse(2, '0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_mondreg", mon_dreg, 32'h0);
    check("async_ready", 32'(monitor_ready), 32'd1);
    check("async_wren", 32'(ram_wren), 32'd0);
    wren_before = wren_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_wren", 32'(wren_cnt), 32'(wren_before));
    check("post_rst_ready", 32'(monitor_ready), 32'd1);
    check("post_rst_mondreg", mon_dreg, 32'h0);
    cpu_rd(8'h10, 32'hDEADBEEF, waits);
    check("post_rst_cpu_waits", 32'(waits), 32'd1);

    repeat (3) @(negedge clk);
    check("mon_q_empty", 32'(exp_mon_q.size()), 32'd0);
    check("cpu_q_empty", 32'(exp_cpu_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/blk_8b790e.md
Name: exponent_accelerator_system_nios2_gen2_0_cpu_debug_ocimem_ctrl

Overview:
Sysclk-domain controller for the Nios II on-chip debug (OCI) memory. It turns the debug slave's decoded JTAG action pulses and 38-bit jdo word into sequenced reads and writes of a single-port debug RAM. It shares that RAM with the CPU's Avalon-MM debug slave port through a round-robin arbiter. It returns read data and status to the JTAG side on MonDReg, monitor_ready and monitor_error.

Parameters:
ADDR_W, 8, debug RAM word-address width (RAM depth 2^ADDR_W 32-bit words)

Ports:
clk  in  1  system clock; every register is on the rising edge
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data word from the debug slave sysclk logic
take_action_ocimem_a  in  1  1-cycle pulse: load address (and optionally read)
take_action_ocimem_b  in  1  1-cycle pulse: write data, then auto-increment
take_no_action_ocimem_a  in  1  1-cycle pulse: read, then auto-increment
cpu_address  in  ADDR_W  CPU word address
cpu_read  in  1  CPU read request
cpu_write  in  1  CPU write request
cpu_writedata  in  32  CPU write data
cpu_byteenable  in  4  CPU byte enables
cpu_readdata  out  32  CPU read data
cpu_waitrequest  out  1  Avalon waitrequest
ram_address  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_byteen  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, registered RAM, 1-cycle latency
MonDReg  out  32  last JTAG read data
monitor_ready  out  1  JTAG operation complete / controller idle
monitor_error  out  1  sticky: JTAG action dropped

Behaviour:
- Reset values: MonDReg=0, monitor_ready=1, monitor_error=0, jtag_addr=0, jtag pending=0, FSM=IDLE, last_grant=CPU, ram_wren=0, cpu_readdata=0.
- Reset is asynchronous and can occur mid-operation. It drops any pending or in-flight op and no ram_wren pulse may follow.
- JTAG decode, with at most one action pulse per cycle:
  - ocimem_a: jtag_addr <= jdo[17+ADDR_W-1:17]; monitor_error <= 0. If jdo[34]=1, queue a read of the new address.
  - ocimem_b: queue a write of jdo[34:3], all byteen=4'hF, to jtag_addr.
  - no_action_ocimem_a: queue a read of jtag_addr.
- An accepted queued op drops monitor_ready to 0 on the next cycle.
- Any action pulse (ocimem_a included) arriving while an op is pending or in flight is ignored entirely and sets monitor_error=1. An ocimem_a with jdo[34]=0 while idle never sets pending.
- jtag_addr auto-increments by 1 after each completed queued read or write, modulo 2^ADDR_W (wraps from all-ones to 0).
- FSM states: IDLE, JTAG_RD, CPU_RD.
  - IDLE: the requester set is {JTAG pending, cpu_read|cpu_write}. If both are requesting, grant the one that is not last_grant; otherwise grant the sole requester. A grant updates last_grant.
  - Grant cycle drives ram_address, plus ram_wren/ram_wdata/ram_byteen for writes.
  - JTAG write: completes in the grant cycle. Next cycle monitor_ready=1 and pending=0. FSM stays IDLE.
  - JTAG read: IDLE -> JTAG_RD. In JTAG_RD, MonDReg <= ram_rdata, monitor_ready <= 1, jtag_addr++, then -> IDLE.
  - CPU write: cpu_waitrequest=0 in the grant cycle. FSM stays IDLE.
  - CPU read: IDLE -> CPU_RD with cpu_waitrequest=1. In CPU_RD, cpu_readdata=ram_rdata and cpu_waitrequest=0, then -> IDLE.
- cpu_waitrequest=1 whenever cpu_read|cpu_write is high and the CPU transfer is not completing this cycle. It is 0 when the CPU is idle.
- cpu_read and cpu_write both high is illegal; write takes precedence.
- ram_wren is high only in a write grant cycle. No grant is issued in JTAG_RD or CPU_RD, so the RAM sees at most one access per two cycles for reads.

Test Plan:
- Reset, then ocimem_a with jdo[17+:8]=8'h10, jdo[34]=0 -> jtag_addr=0x10, monitor_ready stays 1, no RAM access.
- ocimem_b with jdo[34:3]=32'hDEADBEEF, then no_action_ocimem_a preceded by ocimem_a to 0x10 -> RAM[0x10]=DEADBEEF, MonDReg=DEADBEEF two cycles after the read pulse, monitor_ready 1->0->1, jtag_addr=0x11.
- jtag_addr=0xFF, ocimem_b -> write lands at 0xFF and jtag_addr wraps to 0x00.
- JTAG read pending and cpu_read asserted the same cycle with last_grant=CPU -> JTAG granted first, cpu_waitrequest held 1, CPU readdata returned exactly 2 cycles after the JTAG read completes.
- Second ocimem_b while the first is pending, CPU hogging the RAM -> only the first write executes, monitor_error=1, cleared by the next ocimem_a.
- Assert reset_n=0 in the JTAG_RD cycle -> MonDReg=0, monitor_ready=1, FSM IDLE immediately (asynchronously), no ram_wren afterwards.
